// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead adder/subtractor, one 4-bit group per stage
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    localparam int NSTAGE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
            $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k registers; operand words travel whole, each stage consumes its own 4-bit slice.
    logic [WIDTH-1:0] a_q  [NSTAGE];
    logic [WIDTH-1:0] b_q  [NSTAGE];
    logic [WIDTH-1:0] s_q  [NSTAGE];
    logic             co_q [NSTAGE];
    logic             cm_q [NSTAGE];
    logic             v_q  [NSTAGE];

    logic [WIDTH-1:0] in_a [NSTAGE];
    logic [WIDTH-1:0] in_b [NSTAGE];
    logic [WIDTH-1:0] in_s [NSTAGE];
    logic [WIDTH-1:0] nx_s [NSTAGE];
    logic             in_c [NSTAGE];
    logic             nx_v [NSTAGE];
    logic [5:0]       grp  [NSTAGE];

    // Returns {carry out, carry into bit 3, 4-bit sum}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, c3, p ^ {c3, c2, c1, ci}};
    endfunction

    always_comb begin
        in_a[0] = a;
        in_b[0] = sub ? ~b : b;
        in_c[0] = sub | cin;
        in_s[0] = '0;
        nx_v[0] = in_valid;
        for (int k = 1; k < NSTAGE; k++) begin
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_c[k] = co_q[k-1];
            in_s[k] = s_q[k-1];
            nx_v[k] = v_q[k-1];
        end
        for (int k = 0; k < NSTAGE; k++) begin
            grp[k]            = cla4(in_a[k][4*k +: 4], in_b[k][4*k +: 4], in_c[k]);
            nx_s[k]           = in_s[k];
            nx_s[k][4*k +: 4] = grp[k][3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                co_q[k] <= 1'b0;
                cm_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k]  <= nx_v[k];
                a_q[k]  <= in_a[k];
                b_q[k]  <= in_b[k];
                s_q[k]  <= nx_s[k];
                co_q[k] <= grp[k][5];
                cm_q[k] <= grp[k][4];
            end
        end
    end

    assign out_valid = v_q[NSTAGE-1];
    assign sum       = s_q[NSTAGE-1];
    assign cout      = co_q[NSTAGE-1];
    assign ovf       = co_q[NSTAGE-1] ^ cm_q[NSTAGE-1];

    // Final-stage operand copies have no consumer.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{a_q[NSTAGE-1], b_q[NSTAGE-1]};

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe at WIDTH=16 and WIDTH=4
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        iv4, ir4, ci4, sb4, ov4, or4, co4, of4;
    logic [3:0]  a4, b4, s4;

    int total = 0;
    int bad   = 0;

    cla_adder_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16)
    );

    cla_adder_pipe #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(or4), .sum(s4),
        .cout(co4), .ovf(of4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: returns {ovf, cout, sum[15:0]} for a w-bit operation.
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic sb);
        logic [31:0] mask, yy, t;
        logic [15:0] s;
        logic        co, ov;
        mask = (32'd1 << w) - 32'd1;
        yy   = sb ? (~{16'd0, y}) & mask : {16'd0, y};
        t    = {16'd0, x} + yy + (sb ? 32'd1 : {31'd0, ci});
        s    = t[15:0] & mask[15:0];
        co   = t[w];
        ov   = (x[w-1] == yy[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt[8];

    task automatic one_shot(input int idx);
        int edges;
        @(negedge clk);
        a16 = vt[idx].a; b16 = vt[idx].b; ci16 = vt[idx].cin; sb16 = vt[idx].sub; iv16 = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        iv16 = 1'b0;
        while (!ov16 && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check($sformatf("vec%0d_latency", idx), edges, 4);
        check($sformatf("vec%0d_sum", idx), s16, vt[idx].s);
        check($sformatf("vec%0d_cout", idx), co16, vt[idx].co);
        check($sformatf("vec%0d_ovf", idx), of16, vt[idx].ov);
    endtask

    task automatic run_stream(input int n, input bit rnd, input string tag);
        logic [17:0] q[$];
        logic [17:0] held, exp;
        bit          hold;
        int          sent, got, cyc;
        logic [15:0] na, nb;
        logic        nc, ns, exp_rdy;
        sent = 0; got = 0; cyc = 0; hold = 0; held = '0;
        na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom); ns = 1'($urandom);
        while (got < n && cyc < n * 10 + 50) begin
            @(negedge clk);
            or16 = rnd ? ($urandom_range(3) != 0) : !(cyc >= 5 && cyc < 8);
            iv16 = (sent < n) && (rnd ? ($urandom_range(1) == 1) : 1'b1);
            a16 = na; b16 = nb; ci16 = nc; sb16 = ns;
            #1;
            exp_rdy = rnd ? (!ov16 || or16) : or16;
            check({tag, "_in_ready"}, ir16, exp_rdy);
            if (hold) check({tag, "_hold"}, {of16, co16, s16}, held);
            hold = ov16 && !or16;
            held = {of16, co16, s16};
            if (ov16 && or16) begin
                if (q.size() == 0) begin
                    check({tag, "_extra_result"}, 1, 0);
                end else begin
                    exp = q.pop_front();
                    check({tag, "_result"}, {of16, co16, s16}, exp);
                    got++;
                end
            end
            if (iv16 && ir16) begin
                q.push_back(ref_add(16, na, nb, nc, ns));
                sent++;
                na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom); ns = 1'($urandom);
            end
            cyc++;
        end
        check({tag, "_count"}, got, n);
        @(negedge clk);
        iv16 = 1'b0;
        or16 = 1'b1;
    endtask

    initial begin
        logic [17:0] exp4;
        logic [9:0]  iv;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1};
        vt[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; sb16 = 0; or16 = 1;
        iv4 = 0; a4 = 0; b4 = 0; ci4 = 0; sb4 = 0; or4 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", ov16, 0);
        check("rst_sum", s16, 0);
        check("rst_cout", co16, 0);
        check("rst_ovf", of16, 0);
        check("rst_in_ready", ir16, 1);
        check("rst_out_valid_w4", ov4, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) one_shot(i);

        run_stream(8, 1'b0, "stream8");
        run_stream(200, 1'b1, "rand");

        // Reset with three transactions in flight.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'b1; sb16 = 1'b0;
        end
        @(negedge clk);
        check("flush_pre_valid", ov16, 0);
        iv16 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("flush_out_valid", ov16, 0);
        check("flush_sum", s16, 0);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("flush_stale_%0d", j), ov16, 0);
        end

        // WIDTH=4 exhaustive, back to back, one-edge latency.
        exp4 = '0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i > 0) check($sformatf("w4_vec%0d", i - 1), {ov4, of4, co4, s4}, {1'b1, exp4[17:16], exp4[3:0]});
            iv = 10'(i);
            a4 = iv[3:0]; b4 = iv[7:4]; ci4 = iv[8]; sb4 = iv[9]; iv4 = 1'b1;
            exp4 = ref_add(4, {12'd0, iv[3:0]}, {12'd0, iv[7:4]}, iv[8], iv[9]);
        end
        @(negedge clk);
        check("w4_vec1023", {ov4, of4, co4, s4}, {1'b1, exp4[17:16], exp4[3:0]});
        iv4 = 1'b0;
        @(negedge clk);
        check("w4_drain", ov4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder/subtractor. It is the multi-width successor to the team's 4-bit CLA. The datapath is split into 4-bit CLA groups, one group per pipeline stage, with the inter-group carry registered between stages. It accepts one operand pair per cycle under a valid/ready handshake and sits between operand-issue logic and the result writeback path.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and ≥ 4; any other value is an elaboration error.
- `NSTAGE`, derived as WIDTH/4: number of pipeline stages. Not overridable.
- `clk`  input  1: single clock. All logic is on the rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `in_valid`  input  1: operand pair presented.
- `in_ready`  output  1: the pipeline can accept this cycle.
- `a`  input  WIDTH: operand A.
- `b`  input  WIDTH: operand B.
- `cin`  input  1: carry-in. Ignored when `sub`=1.
- `sub`  input  1: 0 computes a+b+cin; 1 computes a−b.
- `out_valid`  output  1: result present.
- `out_ready`  input  1: the consumer takes the result this cycle.
- `sum`  output  WIDTH: result, modulo 2^WIDTH.
- `cout`  output  1: carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`  output  1: signed overflow, computed as carry into MSB XOR carry out of MSB.

## Operation
- Effective operands:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
  - Result = a + b_eff + c0, computed as WIDTH+1 bits: {cout, sum}.
- Group g (bits 4g+3..4g) uses standard 4-bit lookahead:
  - p = a^b_eff, g = a&b_eff
  - Group carries come from the CLA equations, not a ripple chain.
- Pipeline structure:
  - Stage k computes group k from its registered operand slice and the carry registered by stage k−1.
  - Stage k registers: sum bits 0..4k+3, carry out, carry into bit 4k+3, and the not-yet-consumed upper operand bits.
  - Stage 0 takes operands directly from the `a`, `b`, `sub`, `cin` ports.
- Each stage holds a valid bit. Global advance: adv = !out_valid || out_ready.
  - When adv=1, every stage loads from its predecessor, and its valid bit copies the predecessor's valid bit.
  - Stage 0's valid loads in_valid && in_ready.
  - When adv=0, all stages hold, including data.
- `in_ready` = adv, combinational from `out_valid`/`out_ready`. This is the only combinational input-to-output path.
- `out_valid` is the valid bit of stage NSTAGE−1. `sum`/`cout`/`ovf` are that stage's registers.
- Results leave strictly in acceptance order. No transaction is dropped or duplicated.
- Data presented while in_valid=0 is ignored. `in_ready` can be high while in_valid=0.

## Timing
- Reset (rst_n=0 at a rising edge):
  - All stage valid bits clear.
  - `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0.
  - `in_ready`=1 in the cycle after reset, unless out_ready forces otherwise (it cannot, because out_valid=0).
- Reset mid-operation flushes every in-flight transaction. No result accepted before reset ever appears at the output.
- Latency: operands accepted at rising edge E appear with out_valid=1 immediately after edge E+NSTAGE−1.
  - WIDTH=16: 4 edges inclusive, i.e. valid after the 4th edge counting E.
  - WIDTH=4: valid immediately after E.
- Throughput: one result per cycle while out_ready=1.
- Backpressure:
  - out_valid=1 && out_ready=0 → in_ready=0 in the same cycle.
  - `sum`/`cout`/`ovf` are stable until the cycle in which out_ready=1.
- Simultaneous: out_valid=1 && out_ready=1 && in_valid=1 → the result is consumed and a new operand is accepted on the same edge. No bubble.
- Width rules:
  - `sum` wraps modulo 2^WIDTH.
  - `cout` and `ovf` are computed from full-width carries, not from per-group values.

## Test plan
- WIDTH=16, out_ready=1. a=16'hFFFF, b=16'h0001, cin=0, sub=0 → out_valid after 4 edges; sum=16'h0000, cout=1, ovf=0.
- WIDTH=16, sub=1:
  - a=16'h0005, b=16'h0007 → sum=16'hFFFE, cout=0, ovf=0.
  - a=16'h8000, b=16'h0001 → sum=16'h7FFF, cout=1, ovf=1.
- WIDTH=16, a=16'h7FFF, b=16'h0001, cin=1 → sum=16'h8001, cout=0, ovf=1.
- WIDTH=16, stream 8 back-to-back random pairs; drop out_ready for 3 cycles mid-stream:
  - in_ready=0 in exactly those cycles.
  - Outputs held stable.
  - All 8 results correct, in order, no duplicates.
- WIDTH=16, accept 3 transactions, then hold rst_n=0 for one edge → out_valid=0 and sum=0 after that edge; no stale result appears in the following 8 cycles.
- WIDTH=4 exhaustive: all a, b in 0..15 × cin ∈ {0,1} × sub ∈ {0,1}, back-to-back with out_ready=1.
  - Latency is 1 edge.
  - {cout, sum} matches the reference model every cycle.
